// File: rtl/cr16_controller.sv
// CR16 fetch/decode/execute control FSM: fetches 16-bit instructions, keeps the PC,
// decodes R-type / immediate / Bcond into datapath controls and resolves branches.
// Latency: 3 cycles per instruction with zero-wait fetch; holds in FETCH until I_INSTR_VALID.
// Ports: I_CLK/I_NRESET (sync, active-low)/I_ENABLE run control; I_INSTR/I_INSTR_VALID fetch
//   return; I_FLAGS {N,Z,F,L,C}; O_PC/O_FETCH_REQ fetch request; O_REG_ENABLE, O_ALU_ENABLE,
//   O_OPCODE, O_READ_PORT_A/B_SEL, O_IMMEDIATE, O_IMM_SEL datapath controls; O_STATE debug.
module cr16_controller #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        I_CLK,
   input  logic        I_NRESET,
   input  logic        I_ENABLE,
   input  logic [15:0] I_INSTR,
   input  logic        I_INSTR_VALID,
   input  logic [4:0]  I_FLAGS,
   output logic [15:0] O_PC,
   output logic        O_FETCH_REQ,
   output logic [15:0] O_REG_ENABLE,
   output logic        O_ALU_ENABLE,
   output logic [3:0]  O_OPCODE,
   output logic [3:0]  O_READ_PORT_A_SEL,
   output logic [3:0]  O_READ_PORT_B_SEL,
   output logic [15:0] O_IMMEDIATE,
   output logic        O_IMM_SEL,
   output logic [1:0]  O_STATE
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;

   logic [3:0]  op, ext, cond;
   logic [7:0]  imm8;
   logic [15:0] sext_imm;
   logic        is_rtype, is_bcond, is_nop, is_itype, is_alu, writes_reg;
   logic        flag_c, flag_l, flag_f, flag_z, flag_n;
   logic        take_branch;
   logic        exec_active;

   // ---------------- instruction decode (purely from IR) ----------------
   assign op       = ir_q[15:12];
   assign ext      = ir_q[7:4];
   assign cond     = ir_q[11:8];
   assign imm8     = ir_q[7:0];
   assign sext_imm = {{8{imm8[7]}}, imm8};

   assign is_rtype   = (op == 4'h0);
   assign is_bcond   = (op == 4'hC);
   assign is_nop     = (op == 4'h4) || (op == 4'h8);
   assign is_itype   = !(is_rtype || is_bcond || is_nop);
   assign is_alu     = is_rtype || is_itype;
   // CMP (R-type ext 1011) and CMPI (op 1011) only update flags.
   assign writes_reg = (is_rtype && (ext != 4'hB)) || (is_itype && (op != 4'hB));

   always_comb begin
      O_IMMEDIATE = 16'h0000;
      if (is_itype) begin
         case (op)
            4'h5, 4'h9, 4'hB, 4'hE: O_IMMEDIATE = sext_imm;
            4'hF:                   O_IMMEDIATE = {imm8, 8'h00};
            default:                O_IMMEDIATE = {8'h00, imm8};
         endcase
      end
   end

   assign O_OPCODE          = is_rtype ? ext : (is_itype ? op : 4'h0);
   assign O_IMM_SEL         = is_itype;
   assign O_READ_PORT_A_SEL = ir_q[11:8];
   assign O_READ_PORT_B_SEL = ir_q[3:0];

   // ---------------- branch condition ----------------
   assign flag_c = I_FLAGS[0];
   assign flag_l = I_FLAGS[1];
   assign flag_f = I_FLAGS[2];
   assign flag_z = I_FLAGS[3];
   assign flag_n = I_FLAGS[4];

   always_comb begin
      take_branch = 1'b0;
      case (cond)
         4'd0:    take_branch = flag_z;
         4'd1:    take_branch = !flag_z;
         4'd2:    take_branch = flag_c;
         4'd3:    take_branch = !flag_c;
         4'd4:    take_branch = flag_l;
         4'd5:    take_branch = !flag_l;
         4'd6:    take_branch = flag_n;
         4'd7:    take_branch = !flag_n;
         4'd8:    take_branch = flag_f;
         4'd9:    take_branch = !flag_f;
         4'd10:   take_branch = !flag_l && !flag_z;
         4'd11:   take_branch = flag_l || flag_z;
         4'd12:   take_branch = !flag_n && !flag_z;
         4'd13:   take_branch = flag_n || flag_z;
         4'd14:   take_branch = 1'b1;
         default: take_branch = 1'b0;
      endcase
   end

   // Enables are qualified by reset too, so a reset landing in EXECUTE never writes.
   assign exec_active  = (state_q == S_EXECUTE) && I_ENABLE && I_NRESET;
   assign O_ALU_ENABLE = exec_active && is_alu;
   assign O_REG_ENABLE = (exec_active && writes_reg) ? (16'h0001 << cond) : 16'h0000;

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      if (I_ENABLE) begin
         case (state_q)
            S_FETCH: begin
               if (I_INSTR_VALID) begin
                  ir_d    = I_INSTR;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
               // 16-bit adds wrap naturally in both directions.
               pc_d    = (is_bcond && take_branch) ? (pc_q + sext_imm) : (pc_q + 16'h0001);
               state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge I_CLK) begin
      if (!I_NRESET) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   assign O_PC        = pc_q;
   assign O_FETCH_REQ = (state_q == S_FETCH);
   assign O_STATE     = state_q;

endmodule

// File: tb/tb_cr16_controller.sv
// Directed bench for cr16_controller (RESET_PC = 0x0010): walks each instruction
// through FETCH/DECODE/EXECUTE and checks controls, PC update, stalls and reset.
module tb_cr16_controller;

   logic        clk;
   logic        nreset;
   logic        enable;
   logic [15:0] instr;
   logic        instr_valid;
   logic [4:0]  flags;
   logic [15:0] pc;
   logic        fetch_req;
   logic [15:0] reg_enable;
   logic        alu_enable;
   logic [3:0]  opcode;
   logic [3:0]  a_sel;
   logic [3:0]  b_sel;
   logic [15:0] immediate;
   logic        imm_sel;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   cr16_controller #(.RESET_PC(16'h0010)) dut (
      .I_CLK             (clk),
      .I_NRESET          (nreset),
      .I_ENABLE          (enable),
      .I_INSTR           (instr),
      .I_INSTR_VALID     (instr_valid),
      .I_FLAGS           (flags),
      .O_PC              (pc),
      .O_FETCH_REQ       (fetch_req),
      .O_REG_ENABLE      (reg_enable),
      .O_ALU_ENABLE      (alu_enable),
      .O_OPCODE          (opcode),
      .O_READ_PORT_A_SEL (a_sel),
      .O_READ_PORT_B_SEL (b_sel),
      .O_IMMEDIATE       (immediate),
      .O_IMM_SEL         (imm_sel),
      .O_STATE           (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one instruction in FETCH; returns one cycle later, in DECODE.
   task automatic fetch(input logic [15:0] ins, input logic [4:0] flg);
      instr       = ins;
      instr_valid = 1'b1;
      flags       = flg;
      tick();
      instr_valid = 1'b0;
      instr       = 16'h0000;
   endtask

   initial begin
      nreset = 1'b0; enable = 1'b1; instr = 16'h0000; instr_valid = 1'b0; flags = 5'b0;
      tick();
      chk("rst_state", {14'b0, state}, 16'h0000);
      chk("rst_pc", pc, 16'h0010);
      chk("rst_fetch_req", {15'b0, fetch_req}, 16'h0001);
      chk("rst_reg_en", reg_enable, 16'h0000);
      chk("rst_alu_en", {15'b0, alu_enable}, 16'h0000);
      chk("rst_imm", immediate, 16'h0000);
      chk("rst_ctl", {a_sel, b_sel, opcode, 3'b0, imm_sel}, 16'h0000);
      nreset = 1'b1;

      // ADDI r1,#5
      fetch(16'h5105, 5'b0);
      chk("addi_dec_state", {14'b0, state}, 16'h0001);
      chk("addi_dec_req", {15'b0, fetch_req}, 16'h0000);
      chk("addi_dec_op", {12'b0, opcode}, 16'h0005);
      chk("addi_dec_imm", immediate, 16'h0005);
      chk("addi_dec_regen", reg_enable, 16'h0000);
      tick();
      chk("addi_ex_state", {14'b0, state}, 16'h0002);
      chk("addi_ex_regen", reg_enable, 16'h0002);
      chk("addi_ex_aluen", {15'b0, alu_enable}, 16'h0001);
      chk("addi_ex_immsel", {15'b0, imm_sel}, 16'h0001);
      tick();
      chk("addi_pc", pc, 16'h0011);
      chk("addi_back_fetch", {14'b0, state}, 16'h0000);

      // ADD r3,r2
      fetch(16'h0352, 5'b0);
      chk("add_dec_asel", {12'b0, a_sel}, 16'h0003);
      chk("add_dec_bsel", {12'b0, b_sel}, 16'h0002);
      chk("add_dec_op", {12'b0, opcode}, 16'h0005);
      chk("add_dec_immsel", {15'b0, imm_sel}, 16'h0000);
      chk("add_dec_regen", reg_enable, 16'h0000);
      tick();
      chk("add_ex_regen", reg_enable, 16'h0008);
      tick();
      chk("add_fetch_regen", reg_enable, 16'h0000);
      chk("add_pc", pc, 16'h0012);

      // CMPI r4,#-1
      fetch(16'hB4FF, 5'b0);
      tick();
      chk("cmpi_imm", immediate, 16'hFFFF);
      chk("cmpi_aluen", {15'b0, alu_enable}, 16'h0001);
      chk("cmpi_regen", reg_enable, 16'h0000);
      chk("cmpi_op", {12'b0, opcode}, 16'h000B);
      tick();
      chk("cmpi_pc", pc, 16'h0013);

      // BUC +13 -> 0x0020
      fetch(16'hCE0D, 5'b0);
      tick();
      chk("buc_aluen", {15'b0, alu_enable}, 16'h0000);
      chk("buc_regen", reg_enable, 16'h0000);
      tick();
      chk("buc_pc", pc, 16'h0020);

      // BEQ -2, Z=1 -> taken
      fetch(16'hC0FE, 5'b01000);
      tick();
      tick();
      chk("beq_taken_pc", pc, 16'h001E);

      // NOPs back to 0x0020
      fetch(16'h4000, 5'b0);
      tick();
      tick();
      fetch(16'h8000, 5'b0);
      tick();
      chk("nop8_aluen", {15'b0, alu_enable}, 16'h0000);
      chk("nop8_regen", reg_enable, 16'h0000);
      tick();
      chk("nop_pc", pc, 16'h0020);

      // BEQ -2, Z=0 -> not taken
      fetch(16'hC0FE, 5'b10111);
      tick();
      tick();
      chk("beq_nottaken_pc", pc, 16'h0021);

      // LUI r7
      fetch(16'hF7AB, 5'b0);
      chk("lui_imm", immediate, 16'hAB00);
      tick();
      chk("lui_regen", reg_enable, 16'h0080);
      tick();

      // ANDI: zero-extended
      fetch(16'h1380, 5'b0);
      chk("andi_imm", immediate, 16'h0080);
      chk("andi_op", {12'b0, opcode}, 16'h0001);
      tick();
      tick();

      // Op 1110: sign-extended
      fetch(16'hE280, 5'b0);
      chk("op14_imm", immediate, 16'hFF80);
      tick();
      tick();
      chk("op14_pc", pc, 16'h0024);

      // BLO +2 with L=0,Z=0 -> taken; then BGT +5 with N=0 -> not taken
      fetch(16'hCA02, 5'b10101);
      tick();
      tick();
      chk("blo_pc", pc, 16'h0026);
      fetch(16'hC605, 5'b01111);
      tick();
      tick();
      chk("bgt_pc", pc, 16'h0027);

      // Fetch stall: valid low for 4 cycles
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_state", {14'b0, state}, 16'h0000);
         chk("stall_pc", pc, 16'h0027);
      end
      fetch(16'h5105, 5'b0);
      tick();
      enable = 1'b0;
      #1;
      chk("hold_ex_regen", reg_enable, 16'h0000);
      chk("hold_ex_aluen", {15'b0, alu_enable}, 16'h0000);
      tick();
      tick();
      chk("hold_state", {14'b0, state}, 16'h0002);
      chk("hold_pc", pc, 16'h0027);
      chk("hold_regen", reg_enable, 16'h0000);
      enable = 1'b1;
      #1;
      chk("resume_regen", reg_enable, 16'h0002);
      tick();
      chk("resume_state", {14'b0, state}, 16'h0000);
      chk("resume_pc", pc, 16'h0028);
      chk("resume_regen_once", reg_enable, 16'h0000);

      // Reset during EXECUTE
      fetch(16'h5105, 5'b0);
      tick();
      nreset = 1'b0;
      #1;
      chk("rstex_regen", reg_enable, 16'h0000);
      chk("rstex_aluen", {15'b0, alu_enable}, 16'h0000);
      tick();
      chk("rstex_state", {14'b0, state}, 16'h0000);
      chk("rstex_pc", pc, 16'h0010);
      chk("rstex_ir_cleared", {12'b0, opcode}, 16'h0000);
      nreset = 1'b1;

      // BUC -17 -> 0xFFFF, then NOP wraps to 0x0000
      fetch(16'hCEEF, 5'b0);
      tick();
      tick();
      chk("to_ffff_pc", pc, 16'hFFFF);
      fetch(16'h4000, 5'b0);
      tick();
      chk("wrapnop_aluen", {15'b0, alu_enable}, 16'h0000);
      tick();
      chk("wrap_pc", pc, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
